// File: rtl/lcd_bus_responder.sv
// HD44780-style LCD bus responder: decodes writer transfers into a 32-char shadow buffer and models busy timing.
// Optional build macro LCD_RESP_STRICT_TIMING_EN enables strobe-width checking and proto_error reporting.
module lcd_bus_responder #(
    parameter int CLEAR_CYCLES  = 100000,
    parameter int CHAR_CYCLES   = 2000,
    parameter int MIN_EN_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [4:0] cursor,
    output logic       frame_done,
    output logic       cmd_error,
    output logic       proto_error
);

    // state  | meaning
    // IDLE   | ready for a transfer, busy=0
    // DECODE | one cycle applying the latched transfer
    // FILL   | writing 0x20 into buffer index 0..31, one per cycle
    // WAIT   | counting down the remaining busy time
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_FILL, S_WAIT} state_t;

    localparam int TW = ($clog2(CLEAR_CYCLES + 1) > 17) ? $clog2(CLEAR_CYCLES + 1) : 17;
    // DECODE occupies one busy cycle and the terminal-count cycle another, hence the -2.
    localparam logic [TW-1:0] CLEAR_LOAD = TW'(CLEAR_CYCLES - 2);
    localparam logic [TW-1:0] CHAR_LOAD  = TW'(CHAR_CYCLES - 2);

    state_t        state_q, state_d;
    logic          en_q, rs_q, rw_q;
    logic [7:0]    data_q;
    logic          x_rs;
    logic [7:0]    x_data;
    logic [4:0]    fill_idx;
    logic          fill_init;
    logic [TW-1:0] timer;
    logic [4:0]    cursor_q;
    logic [7:0]    mem [32];
    logic [7:0]    rd_char_q;
    logic [7:0]    data_out_q;
    logic          frame_done_q, cmd_error_q, proto_error_q;

    logic          strobe_edge, wr_edge, width_ok, accept, drop_busy;
    logic          cmd_clear, cmd_home, cmd_ddram, addr_line1, addr_line2;
    logic [4:0]    set_idx;
    logic [6:0]    ddram_addr;

`ifdef LCD_RESP_STRICT_TIMING_EN
    logic [7:0]    en_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            en_cnt <= 8'd0;
        else if (lcd_en)
            en_cnt <= (en_cnt == 8'hFF) ? en_cnt : en_cnt + 8'd1;
        else
            en_cnt <= 8'd0;
    end
    assign width_ok = (int'(en_cnt) >= MIN_EN_CYCLES);
`else
    assign width_ok = 1'b1;
`endif

    assign strobe_edge = en_q & ~lcd_en;
    assign wr_edge     = strobe_edge & ~rw_q;
    assign accept      = wr_edge && (state_q == S_IDLE) && !fill_init && width_ok;
    assign drop_busy   = wr_edge && (state_q != S_IDLE);

    assign cmd_clear  = !x_rs && (x_data == 8'h01);
    assign cmd_home   = !x_rs && (x_data[7:1] == 7'b0000001);
    assign cmd_ddram  = !x_rs && x_data[7];
    assign addr_line1 = (x_data[6:4] == 3'b000);
    assign addr_line2 = (x_data[6:4] == 3'b100);
    assign set_idx    = {x_data[6], x_data[3:0]};
    assign ddram_addr = {cursor_q[4], 2'b00, cursor_q[3:0]};

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fill_init)
                    state_d = S_FILL;
                else if (accept)
                    state_d = S_DECODE;
            end
            S_DECODE: state_d = cmd_clear ? S_FILL : S_WAIT;
            S_FILL: begin
                if (fill_idx == 5'd31)
                    state_d = fill_init ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (timer == '0)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q          <= 1'b0;
            rs_q          <= 1'b0;
            rw_q          <= 1'b0;
            data_q        <= 8'h00;
            x_rs          <= 1'b0;
            x_data        <= 8'h00;
            fill_idx      <= 5'd0;
            fill_init     <= 1'b1;
            timer         <= '0;
            cursor_q      <= 5'd0;
            rd_char_q     <= 8'h20;
            data_out_q    <= 8'h00;
            frame_done_q  <= 1'b0;
            cmd_error_q   <= 1'b0;
            proto_error_q <= 1'b0;
        end else begin
            en_q         <= lcd_en;
            rs_q         <= lcd_rs;
            rw_q         <= lcd_rw;
            data_q       <= lcd_data;
            frame_done_q <= 1'b0;
            cmd_error_q  <= 1'b0;
`ifdef LCD_RESP_STRICT_TIMING_EN
            proto_error_q <= drop_busy | (wr_edge & ~width_ok);
`else
            proto_error_q <= 1'b0;
`endif
            if (accept) begin
                x_rs   <= rs_q;
                x_data <= data_q;
            end
            rd_char_q  <= mem[rd_addr];
            data_out_q <= {busy, ddram_addr};
            case (state_q)
                S_DECODE: begin
                    fill_idx <= 5'd0;
                    timer    <= (cmd_clear || cmd_home) ? CLEAR_LOAD : CHAR_LOAD;
                    if (x_rs) begin
                        cursor_q     <= cursor_q + 5'd1;
                        frame_done_q <= (cursor_q == 5'd31);
                    end else if (cmd_clear || cmd_home) begin
                        cursor_q <= 5'd0;
                    end else if (cmd_ddram) begin
                        if (addr_line1 || addr_line2)
                            cursor_q <= set_idx;
                        else
                            cmd_error_q <= 1'b1;
                    end
                end
                S_FILL: begin
                    fill_idx <= fill_idx + 5'd1;
                    if (fill_idx == 5'd31)
                        fill_init <= 1'b0;
                    if (timer != '0)
                        timer <= timer - 1'b1;
                end
                S_WAIT: begin
                    if (timer != '0)
                        timer <= timer - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Buffer has no reset; the post-reset FILL pass initialises it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_DECODE && x_rs)
                mem[cursor_q] <= x_data;
            else if (state_q == S_FILL)
                mem[fill_idx] <= 8'h20;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign lcd_data_oe  = en_q & rw_q;
    assign lcd_data_out = data_out_q;
    assign rd_char      = rd_char_q;
    assign cursor       = cursor_q;
    assign frame_done   = frame_done_q;
    assign cmd_error    = cmd_error_q;
    assign proto_error  = proto_error_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with shortened busy timings.
module tb_lcd_bus_responder;

    localparam int CLEAR = 300;
    localparam int CHAR  = 50;
    localparam int MINEN = 10;
`ifdef LCD_RESP_STRICT_TIMING_EN
    localparam int PE_EXP = 1;
`else
    localparam int PE_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe, busy, frame_done, cmd_error, proto_error;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic [4:0] cursor;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0, ce_cnt = 0, pe_cnt = 0;

    lcd_bus_responder #(.CLEAR_CYCLES(CLEAR), .CHAR_CYCLES(CHAR), .MIN_EN_CYCLES(MINEN)) dut (
        .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data(lcd_data), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
        .busy(busy), .rd_addr(rd_addr), .rd_char(rd_char), .cursor(cursor),
        .frame_done(frame_done), .cmd_error(cmd_error), .proto_error(proto_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (cmd_error === 1'b1) ce_cnt++;
        if (proto_error === 1'b1) pe_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int w);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
        repeat (w) @(negedge clk);
        lcd_en = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic xfer(input logic rs, input logic [7:0] d, input int w, output int n);
        strobe(rs, 1'b0, d, w);
        wait_idle(n);
    endtask

    task automatic rd(input int idx, output logic [7:0] v);
        @(negedge clk);
        rd_addr = idx[4:0];
        @(negedge clk);
        v = rd_char;
    endtask

    initial begin
        int n;
        int snap;
        logic [7:0] v;

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cursor", {27'd0, cursor}, 32'd0);
        chk("rst_rd_char", {24'd0, rd_char}, 32'h20);
        chk("rst_oe", {31'd0, lcd_data_oe}, 32'd0);
        chk("rst_data_out", {24'd0, lcd_data_out}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("init_busy", {31'd0, busy}, 32'd0);
        chk("init_cursor", {27'd0, cursor}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            chk($sformatf("init_buf%0d", i), {24'd0, v}, 32'h20);
        end

        // clear then "LOAD"
        xfer(1'b0, 8'h01, 20, n);
        chk("clear_busy_len", n, CLEAR);
        xfer(1'b1, "L", 20, n);
        chk("char_busy_len", n, CHAR);
        xfer(1'b1, "O", 20, n);
        xfer(1'b1, "A", 20, n);
        xfer(1'b1, "D", 20, n);
        rd(0, v); chk("load0", {24'd0, v}, 32'h4C);
        rd(1, v); chk("load1", {24'd0, v}, 32'h4F);
        rd(2, v); chk("load2", {24'd0, v}, 32'h41);
        rd(3, v); chk("load3", {24'd0, v}, 32'h44);
        chk("load_cursor", {27'd0, cursor}, 32'd4);

        // line-2 address, data, busy-flag read
        xfer(1'b0, 8'hC0, 12, n);
        chk("set_c0_cursor", {27'd0, cursor}, 32'd16);
        xfer(1'b1, "X", 12, n);
        rd(16, v); chk("buf16_X", {24'd0, v}, 32'h58);
        chk("x_cursor", {27'd0, cursor}, 32'd17);
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("read_oe", {31'd0, lcd_data_oe}, 32'd1);
        chk("read_data_out", {24'd0, lcd_data_out}, 32'h41);
        lcd_en = 1'b0;
        @(negedge clk);
        chk("read_oe_off", {31'd0, lcd_data_oe}, 32'd0);
        chk("read_busy", {31'd0, busy}, 32'd0);
        chk("read_cursor", {27'd0, cursor}, 32'd17);
        lcd_rw = 1'b0;

        // unsupported DDRAM address
        snap = ce_cnt;
        xfer(1'b0, 8'h90, 12, n);
        chk("cmd_error_pulses", ce_cnt - snap, 1);
        chk("bad_addr_cursor", {27'd0, cursor}, 32'd17);
        chk("bad_addr_busy_len", n, CHAR);

        // 33 writes from index 0: frame_done on the 32nd, wrap to 0
        xfer(1'b0, 8'h80, 12, n);
        chk("set_80_cursor", {27'd0, cursor}, 32'd0);
        snap = fd_cnt;
        for (int i = 0; i < 33; i++) begin
            xfer(1'b1, 8'h40 + 8'(i), 12, n);
            if (i == 30) chk("frame_done_none_31", fd_cnt - snap, 0);
            if (i == 31) chk("frame_done_at_32", fd_cnt - snap, 1);
        end
        chk("frame_done_after_33", fd_cnt - snap, 1);
        rd(0, v);  chk("wrap_buf0", {24'd0, v}, 32'h60);
        rd(15, v); chk("buf15", {24'd0, v}, 32'h4F);
        rd(16, v); chk("buf16", {24'd0, v}, 32'h50);
        rd(31, v); chk("buf31", {24'd0, v}, 32'h5F);
        chk("wrap_cursor", {27'd0, cursor}, 32'd1);

        // home and a no-effect command
        xfer(1'b0, 8'h02, 12, n);
        chk("home_busy_len", n, CLEAR);
        chk("home_cursor", {27'd0, cursor}, 32'd0);
        rd(5, v); chk("home_buf5", {24'd0, v}, 32'h45);
        xfer(1'b0, 8'h38, 12, n);
        chk("noop_busy_len", n, CHAR);
        chk("noop_cursor", {27'd0, cursor}, 32'd0);

        // data strobe 100 cycles into a clear is dropped and does not touch the timer
        snap = pe_cnt;
        strobe(1'b0, 1'b0, 8'h01, 12);
        repeat (100) @(negedge clk);
        strobe(1'b1, 1'b0, "Z", 12);
        wait_idle(n);
        chk("drop_remaining_busy", n, CLEAR - 113);
        chk("drop_cursor", {27'd0, cursor}, 32'd0);
        rd(0, v);  chk("drop_buf0", {24'd0, v}, 32'h20);
        rd(31, v); chk("drop_buf31", {24'd0, v}, 32'h20);
        chk("drop_proto_error", pe_cnt - snap, PE_EXP);

        // 5-cycle strobe
        snap = pe_cnt;
        xfer(1'b1, "A", 5, n);
        rd(0, v);
`ifdef LCD_RESP_STRICT_TIMING_EN
        chk("short_busy_len", n, 0);
        chk("short_buf0", {24'd0, v}, 32'h20);
        chk("short_cursor", {27'd0, cursor}, 32'd0);
`else
        chk("short_busy_len", n, CHAR);
        chk("short_buf0", {24'd0, v}, 32'h41);
        chk("short_cursor", {27'd0, cursor}, 32'd1);
`endif
        chk("short_proto_error", pe_cnt - snap, PE_EXP);

        // reset during a clear's FILL must refill everything
        xfer(1'b0, 8'hC4, 12, n);
        chk("set_c4_cursor", {27'd0, cursor}, 32'd20);
        xfer(1'b1, "Q", 12, n);
        xfer(1'b1, "R", 12, n);
        xfer(1'b1, "S", 12, n);
        rd(21, v); chk("buf21_R", {24'd0, v}, 32'h52);
        strobe(1'b0, 1'b0, 8'h01, 12);
        repeat (5) @(negedge clk);
        chk("fill_in_progress_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_abort_busy", {31'd0, busy}, 32'd0);
        chk("rst_abort_cursor", {27'd0, cursor}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            chk($sformatf("refill_buf%0d", i), {24'd0, v}, 32'h20);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
